comparator_4b: RTL and testbench

Registered 4-bit magnitude comparator producing mutually exclusive greater/less/equal flags for operands A and B. Supports unsigned or two's-complement comparison, selected per sample. Optional cascade inputs allow chaining several blocks into wider comparators, in the style of a 7485. Sits in the datapath wherever a synchronous, one-hot compare result with a valid qualifier is needed.

---
 rtl/comparator_4b.sv | 135 +++++++++++++
 tb/tb_comparator_4b.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_4b.sv
`default_nettype none
// ============================================================================
// Module   : comparator_4b
// Purpose  : Registered 4-bit magnitude comparator with one-hot
//            greater / less / equal flags and a valid qualifier.
//            Unsigned or two's-complement compare is chosen per sample.
//            Optional 7485-style cascade inputs resolve ties so several
//            blocks can be chained into a wider comparator.
// Build    : define COMPARATOR_4B_CASCADE_EN to add gt_in/lt_in/eq_in.
// Params   : PIPE - output register stages, 1 or 2 (any other value
//            behaves as 2).
// Ports    : clk          in   rising-edge clock
//            rst_n        in   asynchronous active-low reset
//            in_valid     in   qualifies A, B, signed_mode (and cascade)
//            signed_mode  in   0 = unsigned, 1 = two's complement
//            A, B         in   4-bit operands
//            gt_in/lt_in/eq_in in  cascade from less-significant block
//            A_greater_B  out  A > B
//            A_less_B     out  A < B
//            A_equal_B    out  A == B
//            out_valid    out  flags belong to a sample PIPE cycles old
// Revision : 1.0 - initial release
// ============================================================================
module comparator_4b #(
    parameter int PIPE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       signed_mode,
    input  logic [3:0] A,
    input  logic [3:0] B,
`ifdef COMPARATOR_4B_CASCADE_EN
    input  logic       gt_in,
    input  logic       lt_in,
    input  logic       eq_in,
`endif
    output logic       A_greater_B,
    output logic       A_less_B,
    output logic       A_equal_B,
    output logic       out_valid
);

    // ------------------------------------------------------------------
    // Compare. Inverting the sign bit in signed mode maps -8..7 onto
    // 0..15 in order, so one unsigned comparator serves both modes.
    // ------------------------------------------------------------------
    logic [3:0] w_a_key;
    logic [3:0] w_b_key;
    logic       w_gt_raw;
    logic       w_lt_raw;
    logic       w_tie;
    logic [2:0] w_flags;    // {gt, lt, eq}

    assign w_a_key  = {A[3] ^ signed_mode, A[2:0]};
    assign w_b_key  = {B[3] ^ signed_mode, B[2:0]};
    assign w_gt_raw = (w_a_key > w_b_key);
    assign w_lt_raw = (w_a_key < w_b_key);
    assign w_tie    = (A == B);

    always_comb begin
        w_flags = 3'b001;
        if (w_gt_raw) begin
            w_flags = 3'b100;
        end else if (w_lt_raw) begin
            w_flags = 3'b010;
        end else begin
`ifdef COMPARATOR_4B_CASCADE_EN
            // Tie: the less-significant block decides, eq_in first.
            if (eq_in) begin
                w_flags = 3'b001;
            end else if (gt_in) begin
                w_flags = 3'b100;
            end else if (lt_in) begin
                w_flags = 3'b010;
            end else begin
                w_flags = 3'b001;
            end
`else
            w_flags = 3'b001;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Output pipeline. The output flag register only loads on a valid
    // result, so flags hold the last valid compare between samples.
    // ------------------------------------------------------------------
    logic [2:0] r_flags;
    logic       r_valid;

    generate
        if (PIPE == 1) begin : g_pipe1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_flags <= 3'b000;
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= in_valid;
                    if (in_valid) begin
                        r_flags <= w_flags;
                    end
                end
            end
        end else begin : g_pipe2
            logic [2:0] r_s1_flags;
            logic       r_s1_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s1_flags <= 3'b000;
                    r_s1_valid <= 1'b0;
                    r_flags    <= 3'b000;
                    r_valid    <= 1'b0;
                end else begin
                    r_s1_valid <= in_valid;
                    if (in_valid) begin
                        r_s1_flags <= w_flags;
                    end
                    r_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_flags <= r_s1_flags;
                    end
                end
            end
        end
    endgenerate

    assign A_greater_B = r_flags[2];
    assign A_less_B    = r_flags[1];
    assign A_equal_B   = r_flags[0];
    assign out_valid   = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_comparator_4b.sv
`default_nettype none
// ============================================================================
// Module   : tb_comparator_4b
// Purpose  : Self-checking bench for comparator_4b. Drives a PIPE=1 and a
//            PIPE=2 instance with identical stimulus; expected results are
//            queued per instance when stimulus is driven and popped when the
//            corresponding output cycle is sampled.
// Build    : honours COMPARATOR_4B_CASCADE_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_comparator_4b;

`ifdef COMPARATOR_4B_CASCADE_EN
    localparam bit c_casc = 1'b1;
`else
    localparam bit c_casc = 1'b0;
`endif

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] LT = 3'b010;
    localparam logic [2:0] EQ = 3'b001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       signed_mode;
    logic [3:0] A;
    logic [3:0] B;
`ifdef COMPARATOR_4B_CASCADE_EN
    logic       gt_in;
    logic       lt_in;
    logic       eq_in;
`endif
    logic       gt1, lt1, eq1, ov1;
    logic       gt2, lt2, eq2, ov2;

    always #5 clk = ~clk;

    comparator_4b #(.PIPE(1)) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .signed_mode (signed_mode),
        .A           (A),
        .B           (B),
`ifdef COMPARATOR_4B_CASCADE_EN
        .gt_in       (gt_in),
        .lt_in       (lt_in),
        .eq_in       (eq_in),
`endif
        .A_greater_B (gt1),
        .A_less_B    (lt1),
        .A_equal_B   (eq1),
        .out_valid   (ov1)
    );

    comparator_4b #(.PIPE(2)) u_dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .signed_mode (signed_mode),
        .A           (A),
        .B           (B),
`ifdef COMPARATOR_4B_CASCADE_EN
        .gt_in       (gt_in),
        .lt_in       (lt_in),
        .eq_in       (eq_in),
`endif
        .A_greater_B (gt2),
        .A_less_B    (lt2),
        .A_equal_B   (eq2),
        .out_valid   (ov2)
    );

    typedef struct {
        logic       v;
        logic [2:0] flags;
    } exp_t;

    typedef struct {
        logic       v;
        logic       sm;
        logic [3:0] a;
        logic [3:0] b;
        logic       gi;
        logic       li;
        logic       ei;
        logic [2:0] exp;
    } vec_t;

    exp_t       q1[$];
    exp_t       q2[$];
    logic [2:0] last1;
    logic [2:0] last2;
    vec_t       tbl[$];
    int         n_vec = 0;
    int         n_err = 0;

    function automatic vec_t mk(input logic v, input logic sm,
                                input logic [3:0] a, input logic [3:0] b,
                                input logic gi, input logic li, input logic ei,
                                input logic [2:0] exp);
        vec_t r;
        r.v = v; r.sm = sm; r.a = a; r.b = b;
        r.gi = gi; r.li = li; r.ei = ei; r.exp = exp;
        return r;
    endfunction

    // Independent reference: integer compare of the operand values.
    function automatic logic [2:0] ref_cmp(input logic sm, input logic [3:0] a,
                                           input logic [3:0] b, input logic gi,
                                           input logic li, input logic ei);
        int ia;
        int ib;
        ia = int'(a);
        ib = int'(b);
        if (sm && a[3]) ia = ia - 16;
        if (sm && b[3]) ib = ib - 16;
        if (ia > ib) return GT;
        if (ia < ib) return LT;
        if (!c_casc) return EQ;
        if (ei) return EQ;
        if (gi) return GT;
        if (li) return LT;
        return EQ;
    endfunction

    task automatic compare(input string nm, input logic ov, input logic [2:0] f,
                           input logic eov, input logic [2:0] ef);
        n_vec++;
        if (ov !== eov || f !== ef) begin
            n_err++;
            $display("FAIL %s: got out_valid=%b gt/lt/eq=%b, expected out_valid=%b gt/lt/eq=%b",
                     nm, ov, f, eov, ef);
        end
    endtask

    task automatic check_duts(input string tag);
        exp_t e1;
        exp_t e2;
        if (q1.size() == 0 || q2.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got q1=%0d q2=%0d entries, expected >0",
                     tag, q1.size(), q2.size());
            return;
        end
        e1 = q1.pop_front();
        e2 = q2.pop_front();
        if (e1.v) last1 = e1.flags;
        if (e2.v) last2 = e2.flags;
        compare({"pipe1 ", tag}, ov1, {gt1, lt1, eq1}, e1.v, last1);
        compare({"pipe2 ", tag}, ov2, {gt2, lt2, eq2}, e2.v, last2);
    endtask

    // Both instances must read all-zero outputs right now.
    task automatic check_zero(input string tag);
        compare({"pipe1 ", tag}, ov1, {gt1, lt1, eq1}, 1'b0, 3'b000);
        compare({"pipe2 ", tag}, ov2, {gt2, lt2, eq2}, 1'b0, 3'b000);
    endtask

    // After reset the PIPE=2 instance owes one empty output cycle.
    task automatic flush_model();
        exp_t bubble;
        q1.delete();
        q2.delete();
        last1 = 3'b000;
        last2 = 3'b000;
        bubble.v = 1'b0;
        bubble.flags = 3'b000;
        q2.push_back(bubble);
    endtask

    // Called at posedge+1: drive, queue expectation, sample after next edge.
    task automatic step(input logic v, input logic sm, input logic [3:0] a,
                        input logic [3:0] b, input logic gi, input logic li,
                        input logic ei, input logic [2:0] exp, input string tag);
        exp_t e;
        in_valid    = v;
        signed_mode = sm;
        A           = a;
        B           = b;
`ifdef COMPARATOR_4B_CASCADE_EN
        gt_in = gi;
        lt_in = li;
        eq_in = ei;
`endif
        e.v = v;
        e.flags = exp;
        q1.push_back(e);
        q2.push_back(e);
        @(posedge clk);
        #1;
        check_duts(tag);
    endtask

    initial begin
        // -------- reset held with a valid tie on the inputs --------
        rst_n       = 1'b0;
        in_valid    = 1'b1;
        signed_mode = 1'b0;
        A           = 4'd5;
        B           = 4'd5;
`ifdef COMPARATOR_4B_CASCADE_EN
        gt_in = 1'b0;
        lt_in = 1'b0;
        eq_in = 1'b0;
`endif
        #1;
        check_zero("reset at t0");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_zero($sformatf("reset held %0d", i));
        end
        rst_n = 1'b1;
        flush_model();

        // -------- directed table --------
        tbl.push_back(mk(1, 0, 4'd0,  4'd1,  0, 0, 0, LT));
        tbl.push_back(mk(1, 0, 4'd8,  4'd1,  0, 0, 0, GT));
        tbl.push_back(mk(1, 0, 4'd8,  4'd8,  0, 0, 0, EQ));
        tbl.push_back(mk(1, 1, 4'd8,  4'd1,  0, 0, 0, LT));
        tbl.push_back(mk(1, 1, 4'd7,  4'd15, 0, 0, 0, GT));
        tbl.push_back(mk(1, 1, 4'd15, 4'd15, 0, 0, 0, EQ));
        tbl.push_back(mk(1, 0, 4'd7,  4'd15, 0, 0, 0, LT));
        // hold: one valid LT then three idle cycles with moving operands
        tbl.push_back(mk(1, 0, 4'd3,  4'd9,  0, 0, 0, LT));
        tbl.push_back(mk(0, 0, 4'd12, 4'd1,  0, 0, 0, GT));
        tbl.push_back(mk(0, 1, 4'd0,  4'd15, 0, 0, 0, GT));
        tbl.push_back(mk(0, 0, 4'd9,  4'd9,  0, 0, 0, EQ));
        // in_valid toggling each cycle
        tbl.push_back(mk(1, 1, 4'd4,  4'd12, 0, 0, 0, GT));
        tbl.push_back(mk(0, 0, 4'd0,  4'd0,  0, 0, 0, EQ));
        tbl.push_back(mk(1, 0, 4'd4,  4'd12, 0, 0, 0, LT));
        tbl.push_back(mk(0, 1, 4'd1,  4'd0,  0, 0, 0, GT));
        tbl.push_back(mk(1, 0, 4'd15, 4'd0,  0, 0, 0, GT));
        // range boundaries
        tbl.push_back(mk(1, 0, 4'd0,  4'd0,  0, 0, 0, EQ));
        tbl.push_back(mk(1, 0, 4'd15, 4'd15, 0, 0, 0, EQ));
        tbl.push_back(mk(1, 1, 4'd7,  4'd8,  0, 0, 0, GT));
        tbl.push_back(mk(1, 0, 4'd7,  4'd8,  0, 0, 0, LT));
        // cascade tie resolution (ties are plain equal without cascade)
        tbl.push_back(mk(1, 0, 4'd6,  4'd6,  1, 0, 0, c_casc ? GT : EQ));
        tbl.push_back(mk(1, 0, 4'd6,  4'd6,  1, 0, 1, EQ));
        tbl.push_back(mk(1, 0, 4'd2,  4'd6,  1, 0, 0, LT));
        tbl.push_back(mk(1, 0, 4'd6,  4'd6,  0, 1, 0, c_casc ? LT : EQ));
        tbl.push_back(mk(1, 1, 4'd9,  4'd9,  1, 1, 0, c_casc ? GT : EQ));
        tbl.push_back(mk(1, 1, 4'd9,  4'd9,  0, 0, 0, EQ));
        tbl.push_back(mk(1, 1, 4'd9,  4'd2,  0, 1, 1, LT));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].sm, tbl[i].a, tbl[i].b,
                 tbl[i].gi, tbl[i].li, tbl[i].ei, tbl[i].exp,
                 $sformatf("vec%0d", i));
        end
        step(0, 0, 4'd0, 4'd0, 0, 0, 0, EQ, "drain");

        // -------- mid-stream asynchronous reset --------
        step(1, 0, 4'd3, 4'd9, 0, 0, 0, LT, "pre-reset S1");
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("reset immediate");
        in_valid = 1'b1;
        A        = 4'd9;
        B        = 4'd3;
        @(posedge clk);
        #1;
        check_zero("reset over S2 edge");
        rst_n = 1'b1;
        flush_model();
        step(0, 0, 4'd9, 4'd3, 0, 0, 0, GT, "post-reset idle");
        step(1, 0, 4'd9, 4'd3, 0, 0, 0, GT, "post-reset first");
        step(0, 0, 4'd1, 4'd2, 0, 0, 0, LT, "post-reset drain");

        // -------- random traffic against the integer model --------
        for (int i = 0; i < 40; i++) begin
            logic       v;
            logic       sm;
            logic [3:0] a;
            logic [3:0] b;
            logic       gi;
            logic       li;
            logic       ei;
            v  = ($urandom_range(0, 3) != 0);
            sm = 1'($urandom_range(0, 1));
            a  = 4'($urandom_range(0, 15));
            b  = ($urandom_range(0, 3) == 0) ? a : 4'($urandom_range(0, 15));
            gi = 1'($urandom_range(0, 1));
            li = 1'($urandom_range(0, 1));
            ei = 1'($urandom_range(0, 1));
            step(v, sm, a, b, gi, li, ei, ref_cmp(sm, a, b, gi, li, ei),
                 $sformatf("rand%0d", i));
        end
        step(0, 0, 4'd0, 4'd0, 0, 0, 0, EQ, "final drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
